// File: rtl/genel_denetim_birimi.sv
// genel_denetim_birimi
//   Hazard, forwarding and flush controller for the GETIR/COZ/YURUT/GERIYAZ pipeline.
//   Drives the stage-register stall (*_durdur_o) and flush (*_bosalt_o) controls.
//   A flush has priority over a stall in the stage registers.
//
//   Optional build macro: SKORBORD_EN
//     defined   -> register scoreboard for long-latency writers (RAW/WAW stalls)
//     undefined -> plain forwarding and load-use controller; yrt_uzun_basla_i and
//                  gy_uzun_bitti_i are ignored
//
//   Ports
//     clk_i, rst_i               : clock, synchronous active-high reset
//     gtr_yanlis_tahmin_i        : branch mispredict
//     gtr_hazir_i                : fetch valid (0 = L1 miss)
//     gtr_durdur_o/gtr_bosalt_o  : GETIR stall / flush
//     cyo_rs_adres_i             : packed read addresses, port k at [k*ADRES_W +: ADRES_W]
//     cyo_rs_gecerli_i           : per-port read qualifier
//     cyo_rd_adres_i/_yaz_yazmac : COZ destination and write enable
//     cyo_yonlendir_kontrol_o    : per-port forwarding select, 2 bits per port
//     cyo_durdur_o/cyo_bosalt_o  : COZ stall / flush
//     yrt_durdur_o/yrt_bosalt_o  : YURUT stall / bubble insert
//     yrt_*                      : YURUT destination, write enable, readiness, load flag
//     yrt_uzun_basla_i           : YURUT instruction is a long-latency writer
//     gy_*                       : GERIYAZ destination, write enable, long-op completion
module genel_denetim_birimi #(
  parameter int unsigned OKU_PORT         = 2,
  parameter int unsigned ADRES_W          = 5,
  parameter int unsigned BASLANGIC_BOSALT = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          gtr_yanlis_tahmin_i,
  input  logic                          gtr_hazir_i,
  output logic                          gtr_durdur_o,
  output logic                          gtr_bosalt_o,
  input  logic [OKU_PORT*ADRES_W-1:0]   cyo_rs_adres_i,
  input  logic [OKU_PORT-1:0]           cyo_rs_gecerli_i,
  input  logic [ADRES_W-1:0]            cyo_rd_adres_i,
  input  logic                          cyo_yaz_yazmac_i,
  output logic [2*OKU_PORT-1:0]         cyo_yonlendir_kontrol_o,
  output logic                          cyo_durdur_o,
  output logic                          cyo_bosalt_o,
  output logic                          yrt_durdur_o,
  output logic                          yrt_bosalt_o,
  input  logic                          yrt_yonlendir_gecersiz_i,
  input  logic                          yrt_yaz_yazmac_i,
  input  logic                          yrt_hazir_i,
  input  logic [ADRES_W-1:0]            yrt_rd_adres_i,
  input  logic                          yrt_uzun_basla_i,
  input  logic                          gy_yaz_yazmac_i,
  input  logic [ADRES_W-1:0]            gy_rd_adres_i,
  input  logic                          gy_uzun_bitti_i
);

  localparam logic [1:0] YON_HICBISEY = 2'b00;
  localparam logic [1:0] YON_YURUT    = 2'b01;
  localparam logic [1:0] YON_GERIYAZ  = 2'b10;

  localparam int unsigned BOS_W = $clog2(BASLANGIC_BOSALT + 1);

  logic             yuk_durmali;
  logic             skor_durmali;
  logic             tehlike;
  logic             durmus_q, durmus_d;
  logic [BOS_W-1:0] bos_sayac_q, bos_sayac_d;

  // Per-port forwarding select and load-use detection.
  always_comb begin : yonlendirme
    logic [ADRES_W-1:0] rs;
    logic               eslesme_yrt;
    logic               eslesme_gy;
    cyo_yonlendir_kontrol_o = '0;
    yuk_durmali             = 1'b0;
    for (int unsigned k = 0; k < OKU_PORT; k++) begin
      rs          = cyo_rs_adres_i[k*ADRES_W +: ADRES_W];
      eslesme_yrt = cyo_rs_gecerli_i[k] && (rs != '0) && (rs == yrt_rd_adres_i) &&
                    yrt_yaz_yazmac_i;
      eslesme_gy  = cyo_rs_gecerli_i[k] && (rs != '0) && (rs == gy_rd_adres_i) &&
                    gy_yaz_yazmac_i;
      if (eslesme_yrt && !yrt_yonlendir_gecersiz_i) begin
        cyo_yonlendir_kontrol_o[2*k +: 2] = YON_YURUT;
      end else if (eslesme_gy) begin
        cyo_yonlendir_kontrol_o[2*k +: 2] = YON_GERIYAZ;
      end else begin
        cyo_yonlendir_kontrol_o[2*k +: 2] = YON_HICBISEY;
      end
      if (eslesme_yrt && yrt_yonlendir_gecersiz_i) begin
        yuk_durmali = 1'b1;
      end
    end
  end

`ifdef SKORBORD_EN
  localparam int unsigned YAZMAC_N = 1 << ADRES_W;

  logic [YAZMAC_N-1:0] bekleyen_q, bekleyen_d;
  logic [YAZMAC_N-1:0] bekleyen_etkin;

  // A register completing this cycle is no longer pending; it forwards from GERIYAZ.
  always_comb begin
    bekleyen_etkin = bekleyen_q;
    if (gy_uzun_bitti_i) begin
      bekleyen_etkin[gy_rd_adres_i] = 1'b0;
    end
  end

  always_comb begin
    skor_durmali = cyo_yaz_yazmac_i && (cyo_rd_adres_i != '0) &&
                   bekleyen_etkin[cyo_rd_adres_i];
    for (int unsigned k = 0; k < OKU_PORT; k++) begin
      if (cyo_rs_gecerli_i[k] && bekleyen_etkin[cyo_rs_adres_i[k*ADRES_W +: ADRES_W]]) begin
        skor_durmali = 1'b1;
      end
    end
  end

  // Clear first so a same-cycle set wins; a stalled YURUT must not set twice.
  always_comb begin
    bekleyen_d = bekleyen_q;
    if (gy_uzun_bitti_i) begin
      bekleyen_d[gy_rd_adres_i] = 1'b0;
    end
    if (yrt_uzun_basla_i && yrt_yaz_yazmac_i && (yrt_rd_adres_i != '0) && !yrt_durdur_o) begin
      bekleyen_d[yrt_rd_adres_i] = 1'b1;
    end
    bekleyen_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bekleyen_q <= '0;
    end else begin
      bekleyen_q <= bekleyen_d;
    end
  end
`else
  logic skor_unused;
  assign skor_unused  = yrt_uzun_basla_i ^ gy_uzun_bitti_i;
  assign skor_durmali = 1'b0;
`endif

  assign tehlike = ((yuk_durmali && !durmus_q) || skor_durmali) && !gtr_yanlis_tahmin_i;

  // durmus remembers that the one-cycle load-use stall was already taken. It holds
  // during an L1 miss, and a stall suppressed by a mispredict does not count as taken.
  always_comb begin
    durmus_d = durmus_q;
    if (gtr_hazir_i) begin
      durmus_d = durmus_q ? 1'b0 : (yuk_durmali && !gtr_yanlis_tahmin_i);
    end
  end

  always_comb begin
    bos_sayac_d = bos_sayac_q;
    if (bos_sayac_q != '0) begin
      bos_sayac_d = bos_sayac_q - BOS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durmus_q    <= 1'b0;
      bos_sayac_q <= BOS_W'(BASLANGIC_BOSALT);
    end else begin
      durmus_q    <= durmus_d;
      bos_sayac_q <= bos_sayac_d;
    end
  end

  assign gtr_durdur_o = !rst_i && (!yrt_hazir_i || !gtr_hazir_i || tehlike);
  assign cyo_durdur_o = gtr_durdur_o;
  assign yrt_durdur_o = !rst_i && !gtr_hazir_i;
  // Bubble into YURUT while COZ holds the dependent instruction.
  assign yrt_bosalt_o = !rst_i && tehlike && yrt_hazir_i && gtr_hazir_i;
  assign gtr_bosalt_o = rst_i || (bos_sayac_q != '0) || gtr_yanlis_tahmin_i;
  assign cyo_bosalt_o = gtr_bosalt_o;

endmodule
